// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the reduced RV32 datapath (addi, bne).
// Optional feature: define HALT_ON_ILLEGAL_EN to halt on illegal encodings instead of treating them as NOPs.
module multicycle_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     instr,
  input  logic                 imem_valid,
  input  logic                 EQ,
  output logic                 imem_req,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 ALUsrc,
  output logic                 ALUctrl,
  output logic                 ImmSrc,
  output logic                 PCsrc,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired,
  output logic                 halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_I = 3'd2,
    WB     = 3'd3,
    EXEC_B = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 is_addi;
  logic                 is_bne;
  logic                 unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign is_addi           = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_bne            = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign unused_instr_bits = ^{instr[WIDTH-1:15], instr[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Both WB and EXEC_B are the final cycle of their instruction, so they retire it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if ((state_q == WB) || (state_q == EXEC_B)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = 1'b0;
    ImmSrc   = 1'b0;
    PCsrc    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          IRWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_addi) begin
          state_d = EXEC_I;
        end else if (is_bne) begin
          state_d = EXEC_B;
        end else begin
`ifdef HALT_ON_ILLEGAL_EN
          state_d = HALT;
`else
          PCWrite = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      EXEC_I: begin
        ALUsrc  = 1'b1;
        state_d = WB;
      end
      WB: begin
        ALUsrc   = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        state_d  = FETCH;
      end
      EXEC_B: begin
        ALUctrl = 1'b1;
        ImmSrc  = 1'b1;
        PCWrite = 1'b1;
        PCsrc   = ~EQ;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    // Reset dominates every output, whatever state the register still holds.
    if (rst) begin
      imem_req = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUsrc   = 1'b0;
      ALUctrl  = 1'b0;
      ImmSrc   = 1'b0;
      PCsrc    = 1'b0;
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign retired = rst ? '0 : count_q;

`ifdef HALT_ON_ILLEGAL_EN
  assign halted = ~rst && (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl; a second instance with CNT_WIDTH=4 exercises counter wrap.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        imem_valid;
  logic        EQ;

  logic        imem_req, IRWrite, PCWrite, RegWrite, ALUsrc, ALUctrl, ImmSrc, PCsrc;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        halted;

  logic        w_imem_req, w_IRWrite, w_PCWrite, w_RegWrite, w_ALUsrc, w_ALUctrl, w_ImmSrc, w_PCsrc;
  logic [2:0]  w_state;
  logic [3:0]  w_retired;
  logic        w_halted;

  int testCount = 0;
  int failCount = 0;
  int expRet    = 0;

  localparam logic [31:0] ADDI    = 32'h00100513;
  localparam logic [31:0] BNE     = 32'hFE051EE3;
  localparam logic [31:0] ILLEGAL = 32'h00000033;

  // Strobe vector order: {imem_req, IRWrite, PCWrite, RegWrite, ALUsrc, ALUctrl, ImmSrc, PCsrc}
  localparam logic [7:0] S_NONE    = 8'h00;
  localparam logic [7:0] S_FWAIT   = 8'h80;
  localparam logic [7:0] S_FETCH   = 8'hC0;
  localparam logic [7:0] S_EXECI   = 8'h08;
  localparam logic [7:0] S_WB      = 8'h38;
  localparam logic [7:0] S_BTAKEN  = 8'h27;
  localparam logic [7:0] S_BNOT    = 8'h26;
  localparam logic [7:0] S_NOPDEC  = 8'h20;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_valid(imem_valid), .EQ(EQ),
    .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .PCsrc(PCsrc),
    .state(state), .retired(retired), .halted(halted)
  );

  multicycle_ctrl #(.WIDTH(32), .CNT_WIDTH(4)) dutw (
    .clk(clk), .rst(rst), .instr(instr), .imem_valid(imem_valid), .EQ(EQ),
    .imem_req(w_imem_req), .IRWrite(w_IRWrite), .PCWrite(w_PCWrite), .RegWrite(w_RegWrite),
    .ALUsrc(w_ALUsrc), .ALUctrl(w_ALUctrl), .ImmSrc(w_ImmSrc), .PCsrc(w_PCsrc),
    .state(w_state), .retired(w_retired), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic e, input logic [31:0] i);
    rst        = r;
    imem_valid = v;
    EQ         = e;
    instr      = i;
  endtask

  // Checks outputs mid-cycle on the falling edge, then advances to just past the next rising edge.
  task automatic expectCycle(input string tag, input logic [2:0] st, input logic [7:0] strobes,
                             input logic hlt);
    @(negedge clk);
    checkOutput({tag, ".state"}, {29'd0, state}, {29'd0, st});
    checkOutput({tag, ".strobes"},
                {24'd0, imem_req, IRWrite, PCWrite, RegWrite, ALUsrc, ALUctrl, ImmSrc, PCsrc},
                {24'd0, strobes});
    checkOutput({tag, ".retired"}, retired, expRet);
    checkOutput({tag, ".retiredw"}, {28'd0, w_retired}, {28'd0, 4'(expRet)});
    checkOutput({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
    @(posedge clk);
    #1;
  endtask

  task automatic runAddi(input string tag);
    expectCycle({tag, ".fetch"}, 3'd0, S_FETCH, 1'b0);
    expectCycle({tag, ".decode"}, 3'd1, S_NONE, 1'b0);
    expectCycle({tag, ".exec"}, 3'd2, S_EXECI, 1'b0);
    expectCycle({tag, ".wb"}, 3'd3, S_WB, 1'b0);
    expRet++;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0, ADDI);
    expectCycle("rst0", 3'd0, S_NONE, 1'b0);
    expectCycle("rst1", 3'd0, S_NONE, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, ADDI);
    runAddi("addi");

    applyStimulus(1'b0, 1'b1, 1'b0, BNE);
    expectCycle("bne0.fetch", 3'd0, S_FETCH, 1'b0);
    expectCycle("bne0.decode", 3'd1, S_NONE, 1'b0);
    expectCycle("bne0.exec", 3'd4, S_BTAKEN, 1'b0);
    expRet++;
    applyStimulus(1'b0, 1'b1, 1'b1, BNE);
    expectCycle("bne1.fetch", 3'd0, S_FETCH, 1'b0);
    expectCycle("bne1.decode", 3'd1, S_NONE, 1'b0);
    expectCycle("bne1.exec", 3'd4, S_BNOT, 1'b0);
    expRet++;

    applyStimulus(1'b0, 1'b0, 1'b0, ADDI);
    for (int k = 0; k < 3; k++) expectCycle("wait.fetch", 3'd0, S_FWAIT, 1'b0);
    imem_valid = 1'b1;
    runAddi("waitaddi");

    applyStimulus(1'b0, 1'b1, 1'b0, ILLEGAL);
    expectCycle("ill.fetch", 3'd0, S_FETCH, 1'b0);
`ifdef HALT_ON_ILLEGAL_EN
    expectCycle("ill.decode", 3'd1, S_NONE, 1'b0);
    for (int k = 0; k < 20; k++) expectCycle("ill.halt", 3'd5, S_NONE, 1'b1);
    rst = 1'b1;
    expRet = 0;
    expectCycle("ill.rst", 3'd0, S_NONE, 1'b0);
    rst = 1'b0;
`else
    expectCycle("ill.decode", 3'd1, S_NOPDEC, 1'b0);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0, ADDI);
    expectCycle("mid.fetch", 3'd0, S_FETCH, 1'b0);
    expectCycle("mid.decode", 3'd1, S_NONE, 1'b0);
    rst = 1'b1;
    expRet = 0;
    expectCycle("mid.rstexec", 3'd0, S_NONE, 1'b0);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) runAddi("wrap");
    @(negedge clk);
    checkOutput("wrap.retiredw", {28'd0, w_retired}, 32'd0);
    checkOutput("wrap.retired", retired, 32'd16);
    checkOutput("wrap.state", {29'd0, state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
